dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the core's load/store path. It sits on the memory side of the load/store unit. It accepts one load or store request at a time over a valid/ready handshake and applies byte-lane enables derived from funct3 and the address low bits. It stores into an internal word-wide RAM, or reads and returns data right-justified so the load/store unit can sign- or zero-extend it. It inserts a programmable number of wait states and flags misaligned, illegal or out-of-range accesses.

## Interface
Parameters:
- ADDR_W, 10, word-address width; RAM depth is 2^ADDR_W 32-bit words.
- WAIT, 1, extra wait cycles per legal access; legal range 0..15.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  request valid.
- o_ready  out  1  responder can accept a request; high only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_addr  in  32  byte address.
- i_funct3  in  3  RV32I load/store funct3.
- i_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- o_rvalid  out  1  response strobe, exactly one cycle per accepted request.
- o_rdata  out  32  load data, right-justified and zero-filled above the access size; 0 for stores and errors.
- o_err  out  1  access fault; valid with o_rvalid.

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE: o_ready=1. A request is accepted on an edge where i_req && o_ready. On acceptance, i_we, i_addr, i_funct3 and i_wdata are captured.
- Legality is checked on the captured request.
  - Load legal funct3: 000, 001, 010, 100, 101. Store legal funct3: 000, 001, 010.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - Range check: addr[31:ADDR_W+2] must be 0.
  - Any violation is a fault.
- IDLE→RESP on acceptance of a faulting request. RAM is untouched, o_err=1, o_rdata=0.
- IDLE→WAIT on acceptance of a legal request. The counter is loaded with WAIT.
- WAIT: the counter decrements each edge. On the edge where the counter is 0, the access is performed and the state goes to RESP.
- Store byte enables:
  - sb: 4'b0001<<addr[1:0].
  - sh: 4'b0011<<addr[1:0].
  - sw: 4'b1111.
  - Write data is replicated/shifted to lane 8*addr[1:0]. Only enabled bytes change.
- Load: the full word at addr[ADDR_W+1:2] is read and shifted right by 8*addr[1:0].
  - Bytes beyond the access size (1/2/4) are masked to 0.
  - No sign extension here; that is the load/store unit's job.
- RESP: o_rvalid=1 for one cycle, then IDLE. There is no response back-pressure; the core must take the response.
- While not in IDLE, i_req is ignored (o_ready=0).

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - o_ready=1, o_rvalid=0, o_rdata=0, o_err=0.
  - RAM contents are not reset.
- Legal access latency: accept at edge k; RAM access at edge k+1+WAIT; o_rvalid high during the cycle after edge k+2+WAIT. WAIT=0 therefore gives o_rvalid two cycles after acceptance.
- Faulting access: o_rvalid high during the cycle following edge k+1, independent of WAIT.
- o_rdata and o_err are registered. They hold their value until the next response and are meaningful only while o_rvalid=1.
- Back-to-back requests: o_ready returns high in the cycle after RESP. Maximum throughput is one request per WAIT+3 cycles.
- Reset asserted mid-operation:
  - A store whose access edge has not occurred is dropped.
  - A completed write persists.
  - No response is generated; outputs return immediately to their reset values.
- i_req deasserted while o_ready=0 has no effect. There is no cancel mechanism.

## Test plan
- Reset: assert i_rst mid-WAIT on a pending sw 0x11223344 to 0x0. Required: o_ready=1, o_rvalid=0 immediately. A subsequent lw 0x0 returns the prior contents, not 0x11223344.
- Byte/half lanes (WAIT=1):
  - sw 0xAABBCCDD @0x10; sb 0x5A @0x12; sh 0x1234 @0x10.
  - lw @0x10 returns 0xAA5A1234.
  - lb @0x13 returns 0x000000AA.
  - lhu @0x12 returns 0x0000AA5A.
- Latency: WAIT=0 and WAIT=3. Measure acceptance-to-o_rvalid as 2 and 5 cycles respectively. o_rvalid is high for exactly 1 cycle. o_ready is low from acceptance through RESP.
- Faults:
  - lh @0x01, sw @0x02, load funct3=011, sb funct3=100, lw @(4<<ADDR_W).
  - Each gives o_err=1 and o_rdata=0 one cycle after acceptance.
  - RAM is unchanged, verified by read-back.
- Handshake: hold i_req=1 continuously with 4 distinct stores. Each is accepted exactly once, spaced WAIT+3 cycles apart. Read-back confirms all four values.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-wide data RAM behind a one-at-a-time valid/ready load/store port.
// Handles byte-lane enables, right-justified load data, programmable wait states and access faults.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    output logic        o_ready,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request transfers on a rising edge where i_req && o_ready;
    // o_ready is high only in IDLE, and o_rvalid is a single-cycle strobe with no back-pressure.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic              we_q;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic              fault_q;

    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] rword_q;

    logic [31:0] mem [2**ADDR_W];

    logic accept;
    logic f3_ok;
    logic misalign;
    logic out_of_range;
    logic req_fault;
    logic do_access;

    logic [ADDR_W-1:0] widx;
    logic [1:0]        boff;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       shifted;
    logic [31:0]       size_mask;
    logic [31:0]       load_data;

    assign accept    = i_req && (state_q == ST_IDLE);
    assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        f3_ok        = 1'b0;
        misalign     = 1'b0;
        out_of_range = |i_addr[31:ADDR_W+2];
        if (i_we) begin
            f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        end else begin
            f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                    (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
        end
        if (i_funct3[1:0] == 2'b01) misalign = i_addr[0];
        if (i_funct3[1:0] == 2'b10) misalign = (i_addr[1:0] != 2'b00);
        req_fault = !f3_ok || misalign || out_of_range;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = req_fault ? ST_RESP : ST_WAIT;
                    if (!req_fault) cnt_d = 4'(WAIT);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= i_we;
                addr_q  <= i_addr[ADDR_W+1:0];
                size_q  <= i_funct3[1:0];
                wdata_q <= i_wdata;
                fault_q <= req_fault;
            end
        end
    end

    assign widx  = addr_q[ADDR_W+1:2];
    assign boff  = addr_q[1:0];
    assign wlane = wdata_q << {boff, 3'b000};

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'b00:   be = 4'b0001 << boff;
            2'b01:   be = 4'b0011 << boff;
            default: be = 4'b1111;
        endcase
    end

    // RAM is not reset; a store interrupted by reset before its access edge never reaches it.
    always_ff @(posedge i_clk) begin
        if (do_access) begin
            if (we_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
            rword_q <= mem[widx];
        end
    end

    always_comb begin
        shifted   = rword_q >> {boff, 3'b000};
        size_mask = 32'hFFFF_FFFF;
        case (size_q)
            2'b00:   size_mask = 32'h0000_00FF;
            2'b01:   size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
        load_data = shifted & size_mask;
    end

    // Response registers update as RESP is left, so rdata/err hold until the next response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= (state_q == ST_RESP);
            if (state_q == ST_RESP) begin
                err_q   <= fault_q;
                rdata_q <= (fault_q || we_q) ? 32'd0 : load_data;
            end
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array memory model,
// plus directed reset, lane, latency, fault and held-request handshake scenarios.
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int WAIT   = 1;
    localparam int W      = 65;
    localparam int NBYTES = 4 * (2**ADDR_W);

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_wdata = 32'd0;

    logic        o_ready, o_rvalid, o_err;
    logic [31:0] o_rdata;
    logic [1:0]  o_dbg_state;
    logic        w0_ready, w0_rvalid, w0_err;
    logic [31:0] w0_rdata;
    logic [1:0]  w0_dbg_state;
    logic        w3_ready, w3_rvalid, w3_err;
    logic [31:0] w3_rdata;
    logic [1:0]  w3_dbg_state;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ready(o_ready),
        .i_we(i_we), .i_addr(i_addr), .i_funct3(i_funct3), .i_wdata(i_wdata),
        .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err), .o_dbg_state(o_dbg_state)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT(0)) dut_w0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ready(w0_ready),
        .i_we(i_we), .i_addr(i_addr), .i_funct3(i_funct3), .i_wdata(i_wdata),
        .o_rvalid(w0_rvalid), .o_rdata(w0_rdata), .o_err(w0_err), .o_dbg_state(w0_dbg_state)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT(3)) dut_w3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_ready(w3_ready),
        .i_we(i_we), .i_addr(i_addr), .i_funct3(i_funct3), .i_wdata(i_wdata),
        .o_rvalid(w3_rvalid), .o_rdata(w3_rdata), .o_err(w3_err), .o_dbg_state(w3_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   ref_mem [0:NBYTES-1];

    // ---------------- reference model ----------------
    function automatic logic ref_fault(input logic we, input logic [31:0] a, input logic [2:0] f3);
        logic legal;
        int   sz;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        sz = 1 << f3[1:0];
        if ((a % sz) != 0) return 1'b1;
        if (a >= NBYTES) return 1'b1;
        return 1'b0;
    endfunction

    task automatic issue_model(input logic we, input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] wd);
        logic        err;
        logic [31:0] rd;
        int          sz, base, lat;
        err = ref_fault(we, a, f3);
        rd  = 32'd0;
        if (!err) begin
            sz   = 1 << f3[1:0];
            base = int'(a);
            for (int b = 0; b < sz; b++) begin
                if (we) ref_mem[base + b] = wd[8*b +: 8];
                else    rd[8*b +: 8] = ref_mem[base + b];
            end
        end
        lat = err ? 1 : 2 + WAIT;
        exp_q.push_back({32'(cyc + lat), err, rd});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd);
        int guard = 0;
        @(negedge i_clk);
        while (!o_ready && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got o_ready=0 for 200 cycles, required 1");
            return;
        end
        i_req = 1'b1; i_we = we; i_addr = a; i_funct3 = f3; i_wdata = wd;
        @(posedge i_clk);
        @(negedge i_clk);
        issue_model(we, a, f3, wd);
        i_req = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge i_clk);
            g++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        logic [W-1:0] e;
        if (!i_rst && o_rvalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got o_rvalid at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                if ({32'(cyc), o_err, o_rdata} !== e) begin
                    n_bad++;
                    $display("FAIL rsp: got cycle %0d err %b rdata %h, required cycle %0d err %b rdata %h",
                             cyc, o_err, o_rdata, e[64:33], e[32], e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] hs_addr [4];
    logic [31:0] hs_data [4];
    int          acc [4];

    initial begin
        int k, j;
        int first0, first3, cnt0, cnt3;
        logic rdy_ok0, rdy_ok3, sfx_ok;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr;

        repeat (3) @(negedge i_clk);
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_rvalid", 32'(o_rvalid), 32'd0);
        check("reset_rdata", o_rdata, 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;

        // Latency across WAIT=0/1/3 instances sharing one store.
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h50; i_funct3 = 3'd2; i_wdata = 32'h0BAD_F00D;
        @(posedge i_clk);
        @(negedge i_clk);
        issue_model(1'b1, 32'h50, 3'd2, 32'h0BAD_F00D);
        i_req = 1'b0;
        first0 = -1; first3 = -1; cnt0 = 0; cnt3 = 0; rdy_ok0 = 1'b1; rdy_ok3 = 1'b1; sfx_ok = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (w0_rvalid) begin
                cnt0++;
                if (first0 < 0) first0 = n;
                if (w0_err !== 1'b0 || w0_rdata !== 32'd0) sfx_ok = 1'b0;
            end
            if (w3_rvalid) begin
                cnt3++;
                if (first3 < 0) first3 = n;
                if (w3_err !== 1'b0 || w3_rdata !== 32'd0) sfx_ok = 1'b0;
            end
            if (w0_ready !== (n >= 2)) rdy_ok0 = 1'b0;
            if (w3_ready !== (n >= 5)) rdy_ok3 = 1'b0;
            @(negedge i_clk);
        end
        check("lat_wait0", 32'(first0), 32'd2);
        check("lat_wait3", 32'(first3), 32'd5);
        check("rvalid_len_wait0", 32'(cnt0), 32'd1);
        check("rvalid_len_wait3", 32'(cnt3), 32'd1);
        check("ready_window_wait0", 32'(rdy_ok0), 32'd1);
        check("ready_window_wait3", 32'(rdy_ok3), 32'd1);
        check("store_rsp_zero", 32'(sfx_ok), 32'd1);

        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(4 * i), 3'd2, $urandom);
        drain();

        // Reset while a sw is still in WAIT: store must be dropped.
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0; i_funct3 = 3'd2; i_wdata = 32'h1122_3344;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req = 1'b0;
        i_rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_rvalid", 32'(o_rvalid), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        do_req(1'b0, 32'h0, 3'd2, 32'd0);

        // Byte/half lanes.
        do_req(1'b1, 32'h10, 3'd2, 32'hAABB_CCDD);
        do_req(1'b1, 32'h12, 3'd0, 32'h0000_005A);
        do_req(1'b1, 32'h10, 3'd1, 32'h0000_1234);
        do_req(1'b0, 32'h10, 3'd2, 32'd0);
        do_req(1'b0, 32'h13, 3'd0, 32'd0);
        do_req(1'b0, 32'h12, 3'd5, 32'd0);

        // Faults, then read-back of the touched words.
        do_req(1'b0, 32'h01, 3'd1, 32'd0);
        do_req(1'b1, 32'h02, 3'd2, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h04, 3'd3, 32'd0);
        do_req(1'b1, 32'h08, 3'd4, 32'hCAFE_F00D);
        do_req(1'b0, 32'(4 << ADDR_W), 3'd2, 32'd0);
        do_req(1'b1, 32'(4 << ADDR_W), 3'd2, 32'h5555_5555);
        for (int i = 0; i < 3; i++) do_req(1'b0, 32'(4 * i), 3'd2, 32'd0);

        // Held request with four distinct stores.
        for (int i = 0; i < 4; i++) begin
            hs_addr[i] = 32'h20 + 32'(4 * i);
            hs_data[i] = {8'(i + 1), 24'($urandom)};
        end
        @(negedge i_clk);
        j = 0;
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'd2; i_addr = hs_addr[0]; i_wdata = hs_data[0];
        for (int g = 0; g < 200 && j < 4; g++) begin
            if (o_ready) begin
                @(posedge i_clk);
                @(negedge i_clk);
                acc[j] = cyc;
                issue_model(1'b1, hs_addr[j], 3'd2, hs_data[j]);
                j++;
                if (j < 4) begin
                    i_addr = hs_addr[j];
                    i_wdata = hs_data[j];
                end else begin
                    i_req = 1'b0;
                end
            end else begin
                @(negedge i_clk);
            end
        end
        i_req = 1'b0;
        check("hs_accepts", 32'(j), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < j) check("hs_spacing", 32'(acc[i] - acc[i-1]), 32'(WAIT + 3));
        end
        for (int i = 0; i < 4; i++) do_req(1'b0, hs_addr[i], 3'd2, 32'd0);

        // Random traffic.
        for (int t = 0; t < 200; t++) begin
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, rwe ? 2 : 4);
                rf3 = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
            end else begin
                rf3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 15) == 0) raddr = $urandom | 32'h0000_1000;
            else raddr = 32'($urandom_range(0, 63));
            do_req(rwe, raddr, rf3, $urandom);
        end

        for (int i = 0; i < 16; i++) do_req(1'b0, 32'(4 * i), 3'd2, 32'd0);
        drain();
        repeat (5) @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
